// File: rtl/uart_tx_arb_pkg.sv
// Shared types and tag helpers for the UART transmit arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAG_WAIT,
    ST_DATA_WAIT,
    ST_DONE
  } state_t;

  localparam logic TAG_MSB   = 1'b1;
  localparam int   TAG_IDX_W = 3;

  // Marker bit plus source index; the caller zero-fills the bits between them.
  function automatic logic [TAG_IDX_W:0] tag_bits(input logic [TAG_IDX_W-1:0] idx);
    return {TAG_MSB, idx};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             vld
);

  logic [PTR_W:0] sum;

  always_comb begin
    vld = 1'b0;
    idx = '0;
    sum = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
      if (!vld && req[sum[PTR_W-1:0]]) begin
        vld = 1'b1;
        idx = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int k = 0; k < N_REQ; k++) gnt[k] = vld && (idx == PTR_W'(k));
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter, with optional source tag byte
// and a watchdog that aborts a transaction when the transmitter never finishes.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NB_BITS = 8,
  parameter int N_REQ   = 4,
  parameter int TAG_EN  = 1,
  parameter int NB_TO   = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_BITS-1:0] i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic [N_REQ-1:0]         o_err,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_busy,
  output logic                     o_tx_start,
  output logic [NB_BITS-1:0]       o_tx_data,
  input  logic                     i_tx_done
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [NB_TO-1:0] WD_LAST = {NB_TO{1'b1}} - 1'b1;

  state_t               state, state_d;
  logic [PTR_W-1:0]     ptr, ptr_d, win, win_d;
  logic [NB_BITS-1:0]   payload, pay_d, txd_d;
  logic [NB_TO-1:0]     wdog, wdog_d;
  logic [N_REQ-1:0]     grant_d, ack_d, err_d;
  logic                 busy_d, start_d;

  logic [N_REQ-1:0]     pick_gnt;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic [NB_BITS-1:0]   pick_pay, tag_byte;
  logic [TAG_IDX_W:0]   tag_b;
  logic                 done_v, wd_tc;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req (i_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign pick_pay = i_data[pick_idx*NB_BITS +: NB_BITS];
  assign tag_b    = tag_bits(TAG_IDX_W'(pick_idx));
  assign tag_byte = {tag_b[TAG_IDX_W], {(NB_BITS-TAG_IDX_W-1){1'b0}}, tag_b[TAG_IDX_W-1:0]};

  // A done pulse coinciding with our own start pulse belongs to the previous frame.
  assign done_v = i_tx_done && !o_tx_start;
  // The increment taking place this cycle lands on the terminal count.
  assign wd_tc  = (wdog == WD_LAST);

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    win_d   = win;
    pay_d   = payload;
    wdog_d  = wdog;
    grant_d = o_grant;
    ack_d   = '0;
    err_d   = '0;
    start_d = 1'b0;
    txd_d   = o_tx_data;
    unique case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_gnt;
          win_d   = pick_idx;
          pay_d   = pick_pay;
          ptr_d   = (pick_idx == PTR_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
          start_d = 1'b1;
          wdog_d  = '0;
          if (TAG_EN != 0) begin
            txd_d   = tag_byte;
            state_d = ST_TAG_WAIT;
          end else begin
            txd_d   = pick_pay;
            state_d = ST_DATA_WAIT;
          end
        end
      end
      ST_TAG_WAIT: begin
        if (done_v) begin
          txd_d   = payload;
          start_d = 1'b1;
          wdog_d  = '0;
          state_d = ST_DATA_WAIT;
        end else if (wd_tc) begin
          err_d[win] = 1'b1;
          state_d    = ST_DONE;
        end else begin
          wdog_d = wdog + 1'b1;
        end
      end
      ST_DATA_WAIT: begin
        if (done_v) begin
          ack_d[win] = 1'b1;
          state_d    = ST_DONE;
        end else if (wd_tc) begin
          err_d[win] = 1'b1;
          state_d    = ST_DONE;
        end else begin
          wdog_d = wdog + 1'b1;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      win        <= '0;
      payload    <= '0;
      wdog       <= '0;
      o_grant    <= '0;
      o_ack      <= '0;
      o_err      <= '0;
      o_busy     <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      win        <= win_d;
      payload    <= pay_d;
      wdog       <= wdog_d;
      o_grant    <= grant_d;
      o_ack      <= ack_d;
      o_err      <= err_d;
      o_busy     <= busy_d;
      o_tx_start <= start_d;
      o_tx_data  <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: three configurations, a transmitter model and an event scoreboard.
module tb_uart_tx_arbiter;

  localparam int NI = 3;        // 0: tag, long watchdog; 1: tag, NB_TO=4; 2: no tag
  localparam int EV_BYTE = 0;
  localparam int EV_ACK  = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int         inst;
    int         kind;
    logic [7:0] val;
  } ev_t;

  typedef struct {
    int          inst;
    logic [3:0]  req;
    logic [31:0] data;
    int          exp_idx;
    bit          exp_err;
    bit          drop;
    logic [3:0]  req_after;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0][3:0]  req  = '0;
  logic [NI-1:0][31:0] data = '0;
  logic [NI-1:0]       done = '0;
  logic [NI-1:0][3:0]  ack, err, grant;
  logic [NI-1:0]       busy, start;
  logic [NI-1:0][7:0]  txd;

  int lat     [NI] = '{160, 6, 20};
  bit done_en [NI] = '{1'b1, 1'b0, 1'b1};
  int cnt     [NI] = '{-1, -1, -1};
  int last_start [NI] = '{0, 0, 0};
  int cyc = 0;
  int n_tests = 0;
  int n_fail  = 0;
  ev_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_arbiter #(
      .NB_BITS(8), .N_REQ(4), .TAG_EN(g == 2 ? 0 : 1), .NB_TO(g == 1 ? 4 : 9)
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_req      (req[g]),
      .i_data     (data[g]),
      .o_ack      (ack[g]),
      .o_err      (err[g]),
      .o_grant    (grant[g]),
      .o_busy     (busy[g]),
      .o_tx_start (start[g]),
      .o_tx_data  (txd[g]),
      .i_tx_done  (done[g])
    );
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic sb_check(input int g, input int kind, input logic [7:0] val);
    ev_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected inst%0d kind%0d got %h exp none", g, kind, val);
    end else begin
      e = sb.pop_front();
      if (e.inst != g || e.kind != kind || e.val !== val) begin
        n_fail++;
        $display("FAIL sb_event got inst%0d kind%0d val %h exp inst%0d kind%0d val %h",
                 g, kind, val, e.inst, e.kind, e.val);
      end
    end
  endtask

  // Transmitter model (done pulse lat cycles after each start) plus output monitor.
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        done[g] = 1'b0;
        if (cnt[g] > 0) begin
          cnt[g]--;
          if (cnt[g] == 0) begin
            done[g] = 1'b1;
            cnt[g]  = -1;
          end
        end
        if (start[g] && done_en[g]) cnt[g] = lat[g];
        if (start[g]) begin
          sb_check(g, EV_BYTE, txd[g]);
          last_start[g] = cyc;
        end
        if (ack[g] != 0) sb_check(g, EV_ACK, {4'b0, ack[g]});
        if (err[g] != 0) begin
          sb_check(g, EV_ERR, {4'b0, err[g]});
          if (g == 1) check("wd_latency", cyc - last_start[g], 15);
        end
      end
    end
  end

  task automatic push_exp(input vec_t v);
    logic [31:0] d;
    d = v.data;
    if (v.inst != 2) sb.push_back('{v.inst, EV_BYTE, 8'h80 | 8'(v.exp_idx)});
    if (!v.exp_err) sb.push_back('{v.inst, EV_BYTE, d[v.exp_idx*8 +: 8]});
    sb.push_back('{v.inst, v.exp_err ? EV_ERR : EV_ACK, 8'(1 << v.exp_idx)});
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    push_exp(v);
    @(negedge clk);
    req[v.inst]  = v.req;
    data[v.inst] = v.data;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (grant[v.inst] != 0) seen = 1'b1;
      else @(negedge clk);
    end
    check("grant", {28'b0, grant[v.inst]}, 32'(1 << v.exp_idx));
    if (v.drop) begin
      @(negedge clk);
      req[v.inst]  = '0;
      data[v.inst] = '0;
    end
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if ((ack[v.inst] | err[v.inst]) != 0) seen = 1'b1;
      else @(negedge clk);
    end
    check("end_seen", {31'b0, seen}, 1);
    check("end_busy", {31'b0, busy[v.inst]}, 1);
    check("end_grant", {28'b0, grant[v.inst]}, 32'(1 << v.exp_idx));
    req[v.inst] = v.req_after;
    @(negedge clk);
    check("idle_busy", {31'b0, busy[v.inst]}, 0);
    check("idle_grant", {28'b0, grant[v.inst]}, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  vec_t tbl [9];

  initial begin
    bit seen;
    tbl[0] = '{0, 4'b1111, 32'h1312_1110, 0, 1'b0, 1'b0, 4'b1111};
    tbl[1] = '{0, 4'b1111, 32'h1312_1110, 1, 1'b0, 1'b0, 4'b1111};
    tbl[2] = '{0, 4'b1111, 32'h1312_1110, 2, 1'b0, 1'b0, 4'b1111};
    tbl[3] = '{0, 4'b1111, 32'h1312_1110, 3, 1'b0, 1'b0, 4'b1111};
    tbl[4] = '{0, 4'b1111, 32'h1312_1110, 0, 1'b0, 1'b0, 4'b0000};
    tbl[5] = '{0, 4'b0001, 32'h0000_005A, 0, 1'b0, 1'b0, 4'b0000};
    tbl[6] = '{0, 4'b1000, 32'hC300_0000, 3, 1'b0, 1'b0, 4'b0000};
    tbl[7] = '{0, 4'b0101, 32'h0022_0020, 0, 1'b0, 1'b0, 4'b0100};
    tbl[8] = '{0, 4'b0100, 32'h0022_0020, 2, 1'b0, 1'b0, 4'b0000};

    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("rst_busy",  {31'b0, busy[g]},  0);
      check("rst_grant", {28'b0, grant[g]}, 0);
      check("rst_start", {31'b0, start[g]}, 0);
      check("rst_txd",   {24'b0, txd[g]},   0);
    end
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Watchdog abort after the tag, then a normal transaction from the wrapped pointer.
    run_vec('{1, 4'b0010, 32'h0000_5500, 1, 1'b1, 1'b0, 4'b0000});
    done_en[1] = 1'b1;
    run_vec('{1, 4'b0001, 32'h0000_0066, 0, 1'b0, 1'b0, 4'b0000});

    // Untagged payload; requester withdraws (and trashes its data) right after grant.
    run_vec('{2, 4'b0100, 32'h003C_0000, 2, 1'b0, 1'b1, 4'b0000});

    // Reset during DATA_WAIT; the transmitter's late done lands in IDLE.
    sb.push_back('{0, EV_BYTE, 8'h81});
    sb.push_back('{0, EV_BYTE, 8'h99});
    @(negedge clk);
    req[0]  = 4'b0010;
    data[0] = 32'h0000_9900;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (sb.size() == 0) seen = 1'b1;
      else @(negedge clk);
    end
    check("rst_reached_data", {31'b0, seen}, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_grant", {28'b0, grant[0]}, 0);
    check("arst_busy",  {31'b0, busy[0]},  0);
    check("arst_txd",   {24'b0, txd[0]},   0);
    check("arst_ackerr", {24'b0, ack[0], err[0]}, 0);
    req[0] = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("post_rst_busy",  {31'b0, busy[0]},  0);
    check("post_rst_grant", {28'b0, grant[0]}, 0);
    run_vec('{0, 4'b1111, 32'h1312_1110, 0, 1'b0, 1'b0, 4'b0000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
